// File: rtl/snail_bit_serializer_if.sv
// snail_bit_serializer_if: parallel-word handshake in, serial bit stream out, for the snail pattern detector feeder.
interface snail_bit_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             a_out;
    logic             bit_valid;
    logic             last_bit;
    modport master (output data_in, valid_in, input ready_out, a_out, bit_valid, last_bit);
    modport slave  (input data_in, valid_in, output ready_out, a_out, bit_valid, last_bit);
endinterface

// File: rtl/snail_bit_serializer.sv
// snail_bit_serializer: shifts accepted parallel words out one bit per clock on a_out,
// streaming back-to-back words with no gap so detector patterns may straddle word boundaries.
module snail_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input logic clk,
    input logic reset,
    snail_bit_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             a_q, bv_q, lb_q, a_d, at_last, accept;
    assign at_last       = (state_q == SHIFT) && (cnt_q == LAST);
    assign bus.ready_out = (state_q == IDLE) || at_last;
    assign accept        = bus.valid_in && bus.ready_out;
    // The output end of the next shift-register value is the bit for the next cycle,
    // whether that value is a fresh load or a shifted word.
    assign sr_d = accept ? bus.data_in : MSB_FIRST ? sr_q << 1 : sr_q >> 1;
    assign a_d  = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            a_q     <= IDLE_BIT;
            bv_q    <= 1'b0;
            lb_q    <= 1'b0;
        end else if (accept) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            sr_q    <= sr_d;
            a_q     <= a_d;
            bv_q    <= 1'b1;
            lb_q    <= 1'b0;
        end else if (at_last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= IDLE_BIT;
            bv_q    <= 1'b0;
            lb_q    <= 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_q   <= cnt_q + CW'(1);
            sr_q    <= sr_d;
            a_q     <= a_d;
            lb_q    <= (cnt_q + CW'(1)) == LAST;
        end
    end
    assign bus.a_out     = a_q;
    assign bus.bit_valid = bv_q;
    assign bus.last_bit  = lb_q;
endmodule

// File: tb/tb_snail_bit_serializer.sv
// tb_snail_bit_serializer: table-driven directed checks of the serializer across four parameterizations.
module tb_snail_bit_serializer;
    typedef struct {
        int          sel;
        logic        v;
        logic [31:0] d;
        logic        r, a, bv, lb;
        string       nm;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    int          sel = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        o_r, o_a, o_bv, o_lb;
    vec_t        q[$];

    always #5 clk = ~clk;

    snail_bit_serializer_if #(.WIDTH(8)) if0 ();
    snail_bit_serializer_if #(.WIDTH(8)) if1 ();
    snail_bit_serializer_if #(.WIDTH(8)) if2 ();
    snail_bit_serializer_if #(.WIDTH(5)) if3 ();

    snail_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) d0 (.clk(clk), .reset(reset), .bus(if0.slave));
    snail_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) d1 (.clk(clk), .reset(reset), .bus(if1.slave));
    snail_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) d2 (.clk(clk), .reset(reset), .bus(if2.slave));
    snail_bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) d3 (.clk(clk), .reset(reset), .bus(if3.slave));

    assign if0.valid_in = valid && (sel == 0);
    assign if1.valid_in = valid && (sel == 1);
    assign if2.valid_in = valid && (sel == 2);
    assign if3.valid_in = valid && (sel == 3);
    assign if0.data_in  = data[7:0];
    assign if1.data_in  = data[7:0];
    assign if2.data_in  = data[7:0];
    assign if3.data_in  = data[4:0];

    always_comb begin
        o_r  = sel == 0 ? if0.ready_out : sel == 1 ? if1.ready_out : sel == 2 ? if2.ready_out : if3.ready_out;
        o_a  = sel == 0 ? if0.a_out     : sel == 1 ? if1.a_out     : sel == 2 ? if2.a_out     : if3.a_out;
        o_bv = sel == 0 ? if0.bit_valid : sel == 1 ? if1.bit_valid : sel == 2 ? if2.bit_valid : if3.bit_valid;
        o_lb = sel == 0 ? if0.last_bit  : sel == 1 ? if1.last_bit  : sel == 2 ? if2.last_bit  : if3.last_bit;
    end

    task automatic chk(input string nm, input int row, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %b expected %b", nm, row, got, exp);
        end
    endtask

    task automatic add(input int s, input logic v, input logic [31:0] d,
                       input logic r, input logic a, input logic bv, input logic lb, input string nm);
        vec_t t;
        t.sel = s; t.v = v; t.d = d; t.r = r; t.a = a; t.bv = bv; t.lb = lb; t.nm = nm;
        q.push_back(t);
    endtask

    task automatic run();
        foreach (q[i]) begin
            @(negedge clk);
            sel = q[i].sel;
            #1;
            chk({q[i].nm, " ready_out"}, i, o_r,  q[i].r);
            chk({q[i].nm, " a_out"},     i, o_a,  q[i].a);
            chk({q[i].nm, " bit_valid"}, i, o_bv, q[i].bv);
            chk({q[i].nm, " last_bit"},  i, o_lb, q[i].lb);
            valid = q[i].v;
            data  = q[i].d;
        end
        q.delete();
    endtask

    initial begin
        logic [15:0] pat;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk("reset ready_out", s, o_r,  1'b1);
            chk("reset a_out",     s, o_a,  s == 2);
            chk("reset bit_valid", s, o_bv, 1'b0);
            chk("reset last_bit",  s, o_lb, 1'b0);
        end

        pat = 16'b1101_0000_0000_0000;
        add(0, 1, 32'hD0, 1, 0, 0, 0, "single");
        for (int i = 0; i < 8; i++) add(0, 0, 32'bx, i == 7, pat[15-i], 1, i == 7, "single");
        add(0, 0, 32'bx, 1, 0, 0, 0, "single");
        add(0, 0, 32'bx, 1, 0, 0, 0, "single");

        pat = 16'b0000_1101_1011_0000;
        add(0, 1, 32'h0D, 1, 0, 0, 0, "b2b");
        for (int i = 0; i < 16; i++)
            add(0, i < 8, i < 8 ? 32'hB0 : 32'bx, i == 7 || i == 15, pat[15-i], 1, i == 7 || i == 15, "b2b");
        add(0, 0, 32'bx, 1, 0, 0, 0, "b2b");

        pat = 16'b0101_1010_1111_1111;
        add(0, 1, 32'h5A, 1, 0, 0, 0, "stall");
        for (int i = 0; i < 16; i++)
            add(0, i >= 2 && i <= 7, (i >= 2 && i <= 7) ? 32'hFF : 32'bx,
                i == 7 || i == 15, pat[15-i], 1, i == 7 || i == 15, "stall");
        add(0, 0, 32'bx, 1, 0, 0, 0, "stall");
        add(0, 0, 32'bx, 1, 0, 0, 0, "stall");

        pat = 16'b1101_0000_0000_0000;
        add(1, 1, 32'h0B, 1, 0, 0, 0, "lsb_first");
        for (int i = 0; i < 8; i++) add(1, 0, 32'bx, i == 7, pat[15-i], 1, i == 7, "lsb_first");
        add(1, 0, 32'bx, 1, 0, 0, 0, "lsb_first");

        pat = 16'b1101_0110_1000_0000;
        add(3, 1, 32'h1A, 1, 0, 0, 0, "w5");
        for (int i = 0; i < 10; i++)
            add(3, i == 4, i == 4 ? 32'h1A : 32'bx, i == 4 || i == 9, pat[15-i], 1, i == 4 || i == 9, "w5");
        add(3, 0, 32'bx, 1, 0, 0, 0, "w5");
        run();

        pat = 16'b1010_0101_0000_0000;
        add(2, 1, 32'hA5, 1, 1, 0, 0, "pre_rst");
        for (int i = 0; i < 3; i++) add(2, 0, 32'bx, 0, pat[15-i], 1, 0, "pre_rst");
        run();
        @(negedge clk);
        #1;
        chk("mid_rst a_out before", 0, o_a, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst a_out",     0, o_a,  1'b1);
        chk("mid_rst bit_valid", 0, o_bv, 1'b0);
        chk("mid_rst last_bit",  0, o_lb, 1'b0);
        chk("mid_rst ready_out", 0, o_r,  1'b1);
        @(negedge clk);
        reset = 1'b1;
        add(2, 1, 32'hA5, 1, 1, 0, 0, "post_rst");
        for (int i = 0; i < 8; i++) add(2, 0, 32'bx, i == 7, pat[15-i], 1, i == 7, "post_rst");
        add(2, 0, 32'bx, 1, 1, 0, 0, "post_rst");
        run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
